// File: rtl/ecu_pkg.sv
// Shared ECU definitions: pulse generator state encoding and common counter sizing.
package ecu_pkg;

  localparam int unsigned c_DEFAULT_WIDTH   = 16;
  localparam int unsigned c_DEFAULT_MIN_OFF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2,
    OFF    = 2'd3
  } pulse_state_t;

endpackage

// File: rtl/injector_pulse_gen_if.sv
// Scheduler <-> injector pulse generator request/status bundle.
interface injector_pulse_gen_if #(
  parameter int unsigned c_WIDTH = ecu_pkg::c_DEFAULT_WIDTH
);

  logic               i_trigger;
  logic [c_WIDTH-1:0] i_delay;
  logic [c_WIDTH-1:0] i_width;
  logic               i_abort;
  logic               o_enable;
  logic               o_busy;
  logic               o_done;
  logic               o_missed;

  modport master (
    output i_trigger, i_delay, i_width, i_abort,
    input  o_enable, o_busy, o_done, o_missed
  );

  modport slave (
    input  i_trigger, i_delay, i_width, i_abort,
    output o_enable, o_busy, o_done, o_missed
  );

endinterface

// File: rtl/injector_pulse_gen_down_counter.sv
// Loadable saturating down counter; holds at zero instead of wrapping.
module down_counter #(
  parameter int unsigned c_WIDTH = ecu_pkg::c_DEFAULT_WIDTH
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_load,
  input  logic [c_WIDTH-1:0] i_value,
  input  logic               i_enable,
  output logic               o_zero_c
);

  logic [c_WIDTH-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - c_WIDTH'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/injector_pulse_gen.sv
// Injector enable pulse: programmable start delay and width, enforced low time
// after each pulse, synchronous abort; all outputs registered.
module injector_pulse_gen #(
  parameter int unsigned c_WIDTH   = ecu_pkg::c_DEFAULT_WIDTH,
  parameter int unsigned c_MIN_OFF = ecu_pkg::c_DEFAULT_MIN_OFF
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  injector_pulse_gen_if.slave  bus
);

  import ecu_pkg::*;

  localparam logic [c_WIDTH-1:0] c_OFF_LOAD = c_WIDTH'(c_MIN_OFF - 1);

  pulse_state_t       r_state;
  pulse_state_t       w_state_nxt;
  logic               r_enable;
  logic               r_busy;
  logic               r_done;
  logic               r_missed;
  logic               w_enable_nxt;
  logic               w_done_nxt;
  logic               w_missed_nxt;

  logic               w_dly_load;
  logic [c_WIDTH-1:0] w_dly_value;
  logic               w_dly_dec;
  logic               w_dly_zero;
  logic               w_wid_load;
  logic [c_WIDTH-1:0] w_wid_value;
  logic               w_wid_dec;
  logic               w_wid_zero;

  // Delay counter doubles as the OFF-time timer.
  down_counter #(.c_WIDTH(c_WIDTH)) u_delay_cnt (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_load   (w_dly_load),
    .i_value  (w_dly_value),
    .i_enable (w_dly_dec),
    .o_zero_c (w_dly_zero)
  );

  // Width counter holds remaining high cycles minus one, so zero marks the last cycle.
  down_counter #(.c_WIDTH(c_WIDTH)) u_width_cnt (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_load   (w_wid_load),
    .i_value  (w_wid_value),
    .i_enable (w_wid_dec),
    .o_zero_c (w_wid_zero)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_enable <= w_enable_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_done   <= w_done_nxt;
      r_missed <= w_missed_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_enable_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_missed_nxt = bus.i_trigger && (r_state != IDLE);
    w_dly_load   = 1'b0;
    w_dly_value  = '0;
    w_dly_dec    = 1'b0;
    w_wid_load   = 1'b0;
    w_wid_value  = '0;
    w_wid_dec    = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Abort alongside a trigger discards the request silently.
        if (bus.i_trigger && !bus.i_abort) begin
          if (bus.i_width == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = DELAY;
            w_dly_load  = 1'b1;
            w_dly_value = bus.i_delay;
            w_wid_load  = 1'b1;
            w_wid_value = bus.i_width - c_WIDTH'(1);
          end
        end
      end
      DELAY: begin
        if (bus.i_abort) begin
          w_state_nxt = OFF;
          w_dly_load  = 1'b1;
          w_dly_value = c_OFF_LOAD;
        end else if (w_dly_zero) begin
          w_state_nxt  = ACTIVE;
          w_enable_nxt = 1'b1;
        end else begin
          w_dly_dec = 1'b1;
        end
      end
      ACTIVE: begin
        if (bus.i_abort || w_wid_zero) begin
          w_state_nxt = OFF;
          w_done_nxt  = !bus.i_abort;
          w_dly_load  = 1'b1;
          w_dly_value = c_OFF_LOAD;
        end else begin
          w_enable_nxt = 1'b1;
          w_wid_dec    = 1'b1;
        end
      end
      OFF: begin
        if (w_dly_zero) begin
          w_state_nxt = IDLE;
        end else begin
          w_dly_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.o_enable = r_enable;
  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
  assign bus.o_missed = r_missed;

endmodule

// File: tb/tb_injector_pulse_gen.sv
// Directed bench for injector_pulse_gen; expected output vectors {enable,busy,done,missed}
// are hand-derived, with edge 0 being the edge that samples the trigger.
module tb_injector_pulse_gen;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  injector_pulse_gen_if #(.c_WIDTH(16)) bus ();

  injector_pulse_gen #(.c_WIDTH(16), .c_MIN_OFF(4)) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {bus.o_enable, bus.o_busy, bus.o_done, bus.o_missed};
    n_vec++;
    assert (obs === exp)
      else begin
        n_miss++;
        $error("FAIL %s: observed en/busy/done/missed=%b expected %b", tag, obs, exp);
      end
  endtask

  // One clock edge; single-cycle requests are cleared right after being sampled.
  task automatic step(input string tag, input logic [3:0] exp);
    tick();
    bus.i_trigger = 1'b0;
    bus.i_abort   = 1'b0;
    chk(tag, exp);
  endtask

  task automatic steps(input string tag, input int n, input logic [3:0] exp);
    for (int i = 0; i < n; i++) step(tag, exp);
  endtask

  task automatic trig(input logic [15:0] d, input logic [15:0] w);
    bus.i_delay   = d;
    bus.i_width   = w;
    bus.i_trigger = 1'b1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec         = 0;
    n_miss        = 0;
    rst_n         = 1'b1;
    bus.i_trigger = 1'b0;
    bus.i_delay   = '0;
    bus.i_width   = '0;
    bus.i_abort   = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_state", 4'b0000);
    rst_n = 1'b1;
    step("post_reset_idle", 4'b0000);

    // Nominal: delay 3, width 5
    trig(16'd3, 16'd5);
    step ("nom_accept", 4'b0100);
    steps("nom_delay", 3, 4'b0100);
    steps("nom_high", 5, 4'b1100);
    step ("nom_done_fall", 4'b0110);
    steps("nom_off", 3, 4'b0100);
    step ("nom_idle", 4'b0000);
    step ("nom_idle2", 4'b0000);

    // Zero delay
    trig(16'd0, 16'd2);
    step ("d0_accept", 4'b0100);
    steps("d0_high", 2, 4'b1100);
    step ("d0_done", 4'b0110);
    steps("d0_off", 3, 4'b0100);
    step ("d0_idle", 4'b0000);

    // Zero width: no pulse, immediate done
    trig(16'd7, 16'd0);
    step ("w0_done", 4'b0010);
    steps("w0_idle", 2, 4'b0000);

    // Retrigger in DELAY and OFF, with changed inputs left applied
    trig(16'd3, 16'd2);
    step ("rt_accept", 4'b0100);
    trig(16'd0, 16'd9);
    step ("rt_miss_delay", 4'b0101);
    steps("rt_delay", 2, 4'b0100);
    steps("rt_high", 2, 4'b1100);
    step ("rt_done", 4'b0110);
    trig(16'd0, 16'd9);
    step ("rt_miss_off", 4'b0101);
    steps("rt_off", 2, 4'b0100);
    trig(16'd0, 16'd9);
    step ("rt_miss_at_idle", 4'b0001);
    step ("rt_idle", 4'b0000);

    // Fresh acceptance after misses uses new values
    trig(16'd1, 16'd1);
    steps("d1w1_delay", 2, 4'b0100);
    step ("d1w1_high", 4'b1100);
    step ("d1w1_done", 4'b0110);
    steps("d1w1_off", 3, 4'b0100);
    step ("d1w1_idle", 4'b0000);

    // Abort on third high cycle; abort during OFF ignored
    trig(16'd2, 16'd10);
    steps("ab_delay", 3, 4'b0100);
    steps("ab_high", 3, 4'b1100);
    bus.i_abort = 1'b1;
    step ("ab_drop", 4'b0100);
    step ("ab_off1", 4'b0100);
    bus.i_abort = 1'b1;
    step ("ab_off_abort_ignored", 4'b0100);
    step ("ab_off3", 4'b0100);
    step ("ab_idle", 4'b0000);

    // Abort and trigger together in IDLE
    trig(16'd0, 16'd3);
    bus.i_abort = 1'b1;
    step ("ab_trig_idle", 4'b0000);
    step ("ab_trig_idle2", 4'b0000);

    // Asynchronous reset while enable is high
    trig(16'd0, 16'd4);
    step ("rst_accept", 4'b0100);
    step ("rst_high", 4'b1100);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_drop", 4'b0000);
    tick();
    rst_n = 1'b1;
    chk("rst_released", 4'b0000);
    trig(16'd0, 16'd1);
    step ("rst_fresh_accept", 4'b0100);
    step ("rst_fresh_high", 4'b1100);
    step ("rst_fresh_done", 4'b0110);
    steps("rst_fresh_off", 3, 4'b0100);
    step ("rst_fresh_idle", 4'b0000);

    // Maximum delay: enable rises on edge 65536
    trig(16'hFFFF, 16'd1);
    step ("max_accept", 4'b0100);
    repeat (65534) tick();
    step ("max_edge65535", 4'b0100);
    step ("max_rise", 4'b1100);
    step ("max_done", 4'b0110);
    step ("max_off", 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
